// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC register with instruction fetch handshake
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       npc,
    input  logic              pc_en,
    output logic [31:0]       pc,
    output logic [31:0]       pc4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    output logic              addr_err,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;

    state_t      state;
    logic [31:0] pc_off;
    logic [31:0] npc_off;
    logic        npc_legal;

    assign pc4     = pc + 32'd4;
    assign pc_off  = pc - RESET_PC;
    assign npc_off = npc - RESET_PC;
    assign im_addr = ADDR_W'(pc_off >> 2);

    // A target below RESET_PC wraps to a huge offset, so one upper-bits test covers both bounds.
    assign npc_legal = (npc[1:0] == 2'b00) && ((npc_off >> (ADDR_W + 2)) == 32'd0);

    assign im_req      = (state == FETCH);
    assign instr_valid = (state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            addr_err    <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (im_ack) begin
                        instr <= im_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (pc_en) begin
                        if (npc_legal) begin
                            pc          <= npc;
                            fetch_count <= fetch_count + 32'd1;
                            state       <= FETCH;
                        end else begin
                            addr_err <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                ERR: begin
                    addr_err <= 1'b1;
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed plus randomized check of pc_fetch_unit against a reference model
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          ADDR_W   = 10;
    localparam int          WORDS    = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic [31:0]       npc;
    logic              pc_en;
    logic [31:0]       pc;
    logic [31:0]       pc4;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ack;
    logic [31:0]       im_rdata;
    logic              addr_err;
    logic [31:0]       fetch_count;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .npc(npc), .pc_en(pc_en),
        .pc(pc), .pc4(pc4), .instr(instr), .instr_valid(instr_valid),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .addr_err(addr_err), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: instruction held (have), fault latched (err)
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic        m_have;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a);
        longint v;
        v = longint'(a);
        return (a % 4 == 0) && (v >= longint'(RESET_PC)) &&
               (v < longint'(RESET_PC) + 4 * longint'(WORDS));
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = 32'd0;
        m_count = 32'd0;
        m_have  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        if (m_err) begin
        end else if (!m_have) begin
            if (im_ack) begin
                m_instr = im_rdata;
                m_have  = 1'b1;
            end
        end else if (pc_en) begin
            m_have = 1'b0;
            if (is_legal(npc)) begin
                m_pc    = npc;
                m_count = m_count + 1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"}, pc, m_pc);
        check({where, ".pc4"}, pc4, m_pc + 32'd4);
        check({where, ".instr"}, instr, m_instr);
        check({where, ".instr_valid"}, 32'(instr_valid), 32'(m_have));
        check({where, ".im_req"}, 32'(im_req), 32'(!m_have && !m_err));
        check({where, ".im_addr"}, 32'(im_addr), ((m_pc - RESET_PC) / 4) % WORDS);
        check({where, ".addr_err"}, 32'(addr_err), 32'(m_err));
        check({where, ".fetch_count"}, fetch_count, m_count);
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    // asynchronous pulse placed between edges; outputs checked before the next edge
    task automatic reset_pulse(input string where);
        @(posedge clk);
        model_step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(where);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] bad_npc [3];

    initial begin
        reset    = 1'b1;
        npc      = 32'd0;
        pc_en    = 1'b0;
        im_ack   = 1'b0;
        im_rdata = 32'd0;
        model_reset();
        #1;
        check_all("rst_async");
        #20;
        @(negedge clk);
        reset = 1'b0;
        check("t1.pc", pc, 32'h0000_3000);
        check("t1.im_req", 32'(im_req), 32'd1);
        check("t1.im_addr", 32'(im_addr), 32'd0);

        // single fetch then advance
        im_ack = 1'b1; im_rdata = 32'h3C01_0001;
        tick("t2.ack");
        check("t2.valid", 32'(instr_valid), 32'd1);
        check("t2.instr", instr, 32'h3C01_0001);
        im_ack = 1'b0; pc_en = 1'b1; npc = 32'h0000_3004;
        tick("t2.adv");
        check("t2.pc", pc, 32'h0000_3004);
        check("t2.im_addr", 32'(im_addr), 32'd1);
        check("t2.count", fetch_count, 32'd1);

        // 3-cycle memory latency with pc_en held high
        npc = 32'h0000_3008;
        tick("t3.w1");
        tick("t3.w2");
        check("t3.pc_frozen", pc, 32'h0000_3004);
        im_ack = 1'b1; im_rdata = 32'h8C22_0004;
        tick("t3.ack");
        check("t3.valid", 32'(instr_valid), 32'd1);
        im_ack = 1'b0;
        tick("t3.adv");
        check("t3.pc", pc, 32'h0000_3008);
        check("t3.count", fetch_count, 32'd2);

        // stall in HOLD with toggling npc and spurious acks
        pc_en = 1'b0; im_ack = 1'b1; im_rdata = 32'h0000_1111;
        tick("t4.ack");
        for (int i = 0; i < 5; i++) begin
            npc      = (i % 2 == 0) ? 32'h0000_3100 : 32'h0000_0001;
            im_rdata = $urandom;
            tick("t4.stall");
        end
        check("t4.instr", instr, 32'h0000_1111);
        check("t4.im_req", 32'(im_req), 32'd0);

        // async reset mid-FETCH
        im_ack = 1'b0; pc_en = 1'b1; npc = 32'h0000_300C;
        tick("t6.adv");
        pc_en = 1'b0;
        reset_pulse("t6.rst");
        check("t6.pc", pc, 32'h0000_3000);
        im_ack = 1'b1; im_rdata = 32'h2402_0005;
        tick("t6.resume");

        // illegal targets, each from a fresh reset
        bad_npc[0] = 32'h0000_3002;
        bad_npc[1] = 32'h0000_2FFC;
        bad_npc[2] = 32'h0000_4000;
        for (int k = 0; k < 3; k++) begin
            im_ack = 1'b0; pc_en = 1'b0;
            reset_pulse("t5.rst");
            im_ack = 1'b1; im_rdata = 32'hA5A5_0000 + k;
            tick("t5.ack");
            im_ack = 1'b0; pc_en = 1'b1; npc = bad_npc[k];
            tick("t5.bad");
            check("t5.addr_err", 32'(addr_err), 32'd1);
            check("t5.pc", pc, 32'h0000_3000);
            tick("t5.stay");
            pc_en = 1'b0;
            reset_pulse("t5.clear");
            check("t5.cleared", 32'(addr_err), 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            im_ack   = ($urandom_range(0, 2) == 0);
            im_rdata = $urandom;
            pc_en    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 19))
                0:       npc = RESET_PC + 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
                1:       npc = RESET_PC - 32'($urandom_range(1, 64)) * 4;
                2:       npc = RESET_PC + 32'(WORDS) * 4 + 32'($urandom_range(0, 64)) * 4;
                3:       npc = $urandom;
                default: npc = RESET_PC + 32'($urandom_range(0, WORDS - 1)) * 4;
            endcase
            if ($urandom_range(0, 149) == 0 || (m_err && $urandom_range(0, 9) == 0))
                reset_pulse("rnd.rst");
            else
                tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path. Holds the architectural PC register and accepts the computed next PC (npc) each time the core advances.
- Fetches the instruction at PC from instruction memory over a req/ack handshake and presents it to decode with a valid flag.
- Detects misaligned or out-of-range targets and counts retired fetches.
- Sits between the next-PC logic and decode/controller in the MIPS datapath.

Parameters:
RESET_PC  32'h0000_3000  PC value after reset; base byte address of instruction memory
ADDR_W  10  word-index width of instruction memory (capacity 2^ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
npc  input  32  next PC from next-PC logic; sampled only on an advance
pc_en  input  1  advance request from core; 0 = stall
pc  output  32  current PC (registered)
pc4  output  32  pc + 4 (combinational, 32-bit wrap)
instr  output  32  fetched instruction word (registered)
instr_valid  output  1  instr corresponds to current pc
im_req  output  1  memory read request
im_addr  output  ADDR_W  word index = (pc - RESET_PC) >> 2, truncated to ADDR_W
im_ack  input  1  memory read completion; im_rdata valid in the same cycle
im_rdata  input  32  memory read data
addr_err  output  1  sticky fault: rejected npc
fetch_count  output  32  number of accepted advances

Behaviour:
- Reset is asynchronous and active-high and takes effect immediately regardless of clk. Reset values:
  - pc = RESET_PC, instr = 0, instr_valid = 0, addr_err = 0, fetch_count = 0, state = FETCH.
  - im_req is decoded from state, so it reads 1 while reset is held.
- States: FETCH, HOLD, ERR. im_req = (state == FETCH). instr_valid = (state == HOLD). Both are state decodes, not separate flops.
- FETCH:
  - im_addr is driven from pc.
  - On a rising edge with im_ack = 1: instr <= im_rdata, go to HOLD.
  - pc_en is ignored; pc and npc sampling are frozen.
- HOLD:
  - im_req = 0. im_ack is ignored, and so is any spurious ack.
  - With pc_en = 0: stay in HOLD; instr and pc are held.
  - With pc_en = 1 and npc legal: pc <= npc, fetch_count <= fetch_count + 1 (wraps at 2^32), go to FETCH. instr keeps its old value but instr_valid drops.
  - With pc_en = 1 and npc illegal: addr_err <= 1, go to ERR. pc, instr and fetch_count are unchanged.
- npc is legal iff both hold:
  - npc[1:0] == 0
  - (npc - RESET_PC) computed mod 2^32 is < 4 * 2^ADDR_W, i.e. bits [31:ADDR_W+2] of the difference are zero.
  - The low bound is therefore enforced by wrap-around.
- ERR: terminal. im_req = 0, instr_valid = 0, addr_err = 1. Only reset leaves ERR.
- Throughput and latency:
  - Minimum 2 cycles per instruction: ack in cycle N, instr_valid in cycle N+1, advance at the end of N+1.
  - Memory latency of k cycles adds k-1 cycles.
- Reset asserted in FETCH with a request outstanding abandons the request. An ack arriving after reset release is taken as the response for RESET_PC, because req is already reasserted. Memory must drop stale responses on reset.
- pc4 is purely combinational from pc and has no reset dependence beyond pc.

Test Plan:
1. Reset with im_ack held 0 → pc=0x00003000, im_req=1, im_addr=0, instr_valid=0, fetch_count=0, addr_err=0.
2. Ack with im_rdata=0x3C010001, then pc_en=1 with npc=0x00003004 → instr_valid=1 for one cycle; next cycle pc=0x00003004, im_addr=1, im_req=1, fetch_count=1.
3. 3-cycle ack latency with pc_en held 1 throughout → pc constant during FETCH; instr_valid rises exactly one cycle after the ack edge; pc_en during FETCH has no effect.
4. Stall: HOLD with pc_en=0 for 5 cycles while npc toggles → pc and instr stable, im_req=0, spurious im_ack ignored.
5. Illegal npc in HOLD, each case starting from a fresh reset:
   - npc=0x00003002 → addr_err=1, state ERR, pc unchanged, im_req=0, instr_valid=0.
   - npc=0x00002FFC → same response.
   - npc=0x00004000 with ADDR_W=10 → same response.
   - After each case, reset clears addr_err.
6. Asynchronous reset pulsed mid-FETCH between clock edges → outputs return to reset values immediately, before the next edge; fetch resumes at 0x00003000.
